vmem_arbiter: RTL and testbench
===============================

# vmem_arbiter

Arbitrates the single-port pixel memory between the display refill path and a host write port, in the PCLK domain beside simple_480p. It reads pixels for the 640x480 frame into an external pixel FIFO in fixed-length bursts. Host writes are interleaved into the gaps between bursts. A watermark rule guarantees the display never starves, and underruns are flagged sticky per frame.

## Interface
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- ADDRW, 19, memory word address width; one 16-bit word holds one RGB565 pixel
- BURST, 16, words per refill burst
- FIFO_DEPTH, 64, capacity of the external pixel FIFO in words
- LOW_WATER, 16, FIFO level at or below which refill has absolute priority
- PCLK  in  1  pixel clock; the only clock
- RST_PCLK  in  1  synchronous, active-high reset
- FRAME_START  in  1  one-cycle pulse at the start of the vertical blanking preceding a frame
- DE  in  1  display data enable from the timing generator
- FIFO_LEVEL  in  7  current pixel FIFO occupancy
- FIFO_WE  out  1  pixel FIFO write strobe
- FIFO_WDATA  out  16  pixel word to the FIFO
- FIFO_FLUSH  out  1  one-cycle FIFO clear pulse
- HOST_REQ  in  1  host write valid; held until accepted
- HOST_ADDR  in  ADDRW  host write address
- HOST_WDATA  in  16  host write data
- HOST_READY  out  1  one-cycle pulse when the host word transfers
- MEM_REQ  out  1  memory request valid
- MEM_WE  out  1  1 = write, 0 = read
- MEM_ADDR  out  ADDRW  memory word address
- MEM_WDATA  out  16  memory write data
- MEM_ACK  in  1  memory ready; a word transfers on any cycle with MEM_REQ & MEM_ACK
- MEM_RDATA  in  16  read data, valid in the transfer cycle of a read
- UNDERRUN  out  1  sticky flag, set when DE=1 while FIFO_LEVEL=0

## Operation
- FSM states: IDLE, FETCH, HWRITE, DRAIN.
- Fetch pointer: fetch address `faddr` plus word count `fcnt`, both 0..H_RES*V_RES.
  - Fetch is eligible when `fcnt` < H_RES*V_RES and FIFO_LEVEL <= FIFO_DEPTH-BURST.
  - Once `fcnt` reaches H_RES*V_RES, no further fetch occurs until the next FRAME_START.
- Decision in IDLE:
  - If FIFO_LEVEL <= LOW_WATER and fetch is eligible, go to FETCH.
  - Else if HOST_REQ is high and `host_turn` is set, go to HWRITE.
  - Else if fetch is eligible, go to FETCH.
  - Else if HOST_REQ is high, go to HWRITE.
  - Otherwise stay in IDLE.
- `host_turn` is set at the end of each burst and cleared when a host word transfers. This alternates bursts with host words.
- FETCH drives MEM_REQ=1, MEM_WE=0, MEM_ADDR=`faddr`.
  - On each transfer: FIFO_WE=1 and FIFO_WDATA=MEM_RDATA in the same cycle; `faddr` and `fcnt` increment.
  - After BURST transfers, or when `fcnt` reaches H_RES*V_RES (short final burst), go to IDLE. A burst is never preempted.
- HWRITE drives MEM_REQ=1, MEM_WE=1, MEM_ADDR=HOST_ADDR, MEM_WDATA=HOST_WDATA.
  - On transfer: HOST_READY=1, then go to IDLE. Exactly one word per grant.
- FRAME_START:
  - Resets `faddr` and `fcnt` to 0 and pulses FIFO_FLUSH on the next cycle.
  - Clears UNDERRUN unless UNDERRUN is being set in the same cycle; set wins.
  - If it arrives in FETCH, the FSM goes to DRAIN: MEM_REQ stays high until the pending word transfers. That word is discarded (FIFO_WE=0, pointers untouched), then the FSM goes to IDLE.
  - If it arrives in HWRITE, the host write completes normally.
- When not in FETCH or HWRITE: MEM_REQ=0 and FIFO_WE=0. MEM_ADDR and MEM_WDATA are don't-care.
- Arithmetic: `faddr` and `fcnt` are ADDRW-bit unsigned; H_RES*V_RES must be < 2^ADDRW.

## Timing
- Reset values: state=IDLE, all outputs 0, `faddr`=`fcnt`=0, `host_turn`=0, UNDERRUN=0.
- Outputs are registered except FIFO_WE, FIFO_WDATA and HOST_READY, which are combinational from the MEM handshake.
- IDLE-to-request latency: MEM_REQ rises the cycle after the grant decision.
- Returning to IDLE costs one cycle before the next grant.
- Throughput inside a burst is one word per cycle while MEM_ACK=1; a burst occupies at least BURST+1 cycles.
- Simultaneous FRAME_START and a transfer in FETCH: the transfer is discarded and the FSM enters DRAIN with nothing pending, so it goes to IDLE the next cycle.
- Simultaneous FRAME_START and IDLE grant: FRAME_START wins and the grant is re-evaluated the next cycle.
- FIFO_FLUSH and FIFO_WE are never high in the same cycle.
- Reset mid-transaction: MEM_REQ drops the cycle after RST_PCLK is sampled high, with no drain. The memory must tolerate an abandoned request.

## Test plan
- Reset, FRAME_START, MEM_ACK tied 1, FIFO_LEVEL=0 -> MEM_REQ rises two cycles later; 16 reads at addresses 0..15 with FIFO_WE=1 on each; MEM_REQ drops; next burst starts at address 16.
- FIFO_LEVEL=60 (> 48), HOST_REQ=1 with addr 0x100 and data 0xABCD -> one write, MEM_WE=1, HOST_READY pulse; no read issued.
- FIFO_LEVEL=30 with HOST_REQ held high -> bursts and host writes alternate 1:1; then FIFO_LEVEL=10 -> back-to-back bursts with HOST_READY=0 throughout.
- FRAME_START on the 5th word of a burst with MEM_ACK stalled 3 cycles -> DRAIN holds MEM_REQ until the ack; that word is not written to the FIFO; FIFO_FLUSH pulses; the next burst starts at address 0.
- Run a full frame -> exactly 307200 FIFO_WE pulses, last address 307199; no reads until the next FRAME_START.
- DE=1 with FIFO_LEVEL=0 -> UNDERRUN=1 next cycle and stays set; next FRAME_START clears it; set and clear in the same cycle -> UNDERRUN stays 1.

Source files
------------

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares the single-port pixel memory between display
// refill bursts into the pixel FIFO and single-word host writes.
module vmem_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDRW      = 19,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LOW_WATER  = 16
) (
  input  logic             PCLK,
  input  logic             RST_PCLK,
  input  logic             FRAME_START,
  input  logic             DE,
  input  logic [6:0]       FIFO_LEVEL,
  output logic             FIFO_WE,
  output logic [15:0]      FIFO_WDATA,
  output logic             FIFO_FLUSH,
  input  logic             HOST_REQ,
  input  logic [ADDRW-1:0] HOST_ADDR,
  input  logic [15:0]      HOST_WDATA,
  output logic             HOST_READY,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic [ADDRW-1:0] MEM_ADDR,
  output logic [15:0]      MEM_WDATA,
  input  logic             MEM_ACK,
  input  logic [15:0]      MEM_RDATA,
  output logic             UNDERRUN
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HWRITE = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BCW-1:0] BLAST = BCW'(BURST - 1);
  localparam logic [ADDRW-1:0] TOTAL = ADDRW'(H_RES * V_RES);
  localparam logic [6:0] FETCH_MAX = 7'(FIFO_DEPTH - BURST);
  localparam logic [6:0] LOW_MARK = 7'(LOW_WATER);

  logic [1:0]       state_q, state_d;
  logic [ADDRW-1:0] faddr_q, faddr_d;
  logic [ADDRW-1:0] fcnt_q, fcnt_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic             host_turn_q, host_turn_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic             flush_q, flush_d;
  logic             underrun_q, underrun_d;

  logic             xfer;
  logic             fetch_ok;
  logic             fetch_xfer;
  logic             last_word;
  logic             grant_f;
  logic             grant_h;
  logic [ADDRW-1:0] faddr_inc;
  logic [ADDRW-1:0] fcnt_inc;

  always_comb begin
    xfer       = mem_req_q & MEM_ACK;
    faddr_inc  = faddr_q + ADDRW'(1);
    fcnt_inc   = fcnt_q + ADDRW'(1);
    fetch_ok   = (fcnt_q < TOTAL) && (FIFO_LEVEL <= FETCH_MAX);
    fetch_xfer = (state_q == S_FETCH) && xfer && !FRAME_START;
    last_word  = (bcnt_q == BLAST) || (fcnt_inc == TOTAL);
    // A starving FIFO beats the host; otherwise host_turn interleaves.
    grant_f    = fetch_ok &&
                 ((FIFO_LEVEL <= LOW_MARK) || !(HOST_REQ && host_turn_q));
    grant_h    = HOST_REQ && !grant_f;
    FIFO_WE    = fetch_xfer;
    FIFO_WDATA = fetch_xfer ? MEM_RDATA : 16'h0;
    HOST_READY = (state_q == S_HWRITE) && xfer;
  end

  always_comb begin
    state_d     = state_q;
    faddr_d     = faddr_q;
    fcnt_d      = fcnt_q;
    bcnt_d      = bcnt_q;
    host_turn_d = host_turn_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    flush_d     = FRAME_START;
    underrun_d  = underrun_q;

    if (FRAME_START) underrun_d = 1'b0;
    if (DE && (FIFO_LEVEL == 7'd0)) underrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (!FRAME_START && grant_f) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = faddr_q;
          bcnt_d     = '0;
        end else if (!FRAME_START && grant_h) begin
          state_d     = S_HWRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = HOST_ADDR;
          mem_wdata_d = HOST_WDATA;
        end
      end
      S_FETCH: begin
        if (FRAME_START) begin
          // A word acked in this cycle is dropped, nothing left to drain.
          state_d   = S_DRAIN;
          mem_req_d = !xfer;
        end else if (xfer) begin
          faddr_d    = faddr_inc;
          fcnt_d     = fcnt_inc;
          bcnt_d     = bcnt_q + BCW'(1);
          mem_addr_d = faddr_inc;
          if (last_word) begin
            state_d     = S_IDLE;
            mem_req_d   = 1'b0;
            host_turn_d = 1'b1;
          end
        end
      end
      S_HWRITE: begin
        if (xfer) begin
          state_d     = S_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          host_turn_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (!mem_req_q || MEM_ACK) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
    endcase

    if (FRAME_START) begin
      faddr_d = '0;
      fcnt_d  = '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (RST_PCLK) begin
      state_q     <= S_IDLE;
      faddr_q     <= '0;
      fcnt_q      <= '0;
      bcnt_q      <= '0;
      host_turn_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      flush_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      faddr_q     <= faddr_d;
      fcnt_q      <= fcnt_d;
      bcnt_q      <= bcnt_d;
      host_turn_q <= host_turn_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      flush_q     <= flush_d;
      underrun_q  <= underrun_d;
    end
  end

  assign MEM_REQ    = mem_req_q;
  assign MEM_WE     = mem_we_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_WDATA  = mem_wdata_q;
  assign FIFO_FLUSH = flush_q;
  assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: directed stimulus plus a transaction-level model
// of the arbiter, compared against the DUT every cycle.
module tb_vmem_arbiter;

  // Small frame keeps a full-frame run short; 420 = 26*16 + 4.
  localparam int HR = 21;
  localparam int VR = 20;
  localparam int AW = 19;
  localparam int BL = 16;
  localparam int FD = 64;
  localparam int LW = 16;
  localparam int TOTAL = HR * VR;

  logic          clk = 1'b0;
  logic          rst, fs, de, host_req, mem_ack;
  logic [6:0]    level;
  logic [AW-1:0] host_addr;
  logic [15:0]   host_wdata, mem_rdata;
  logic          fifo_we, fifo_flush, host_ready;
  logic          mem_req, mem_we, underrun;
  logic [15:0]   fifo_wdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr[15:0] ^ 16'h5A5A;

  vmem_arbiter #(
    .H_RES(HR), .V_RES(VR), .ADDRW(AW),
    .BURST(BL), .FIFO_DEPTH(FD), .LOW_WATER(LW)
  ) dut (
    .PCLK(clk), .RST_PCLK(rst), .FRAME_START(fs), .DE(de),
    .FIFO_LEVEL(level), .FIFO_WE(fifo_we), .FIFO_WDATA(fifo_wdata),
    .FIFO_FLUSH(fifo_flush), .HOST_REQ(host_req),
    .HOST_ADDR(host_addr), .HOST_WDATA(host_wdata),
    .HOST_READY(host_ready), .MEM_REQ(mem_req), .MEM_WE(mem_we),
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_ACK(mem_ack),
    .MEM_RDATA(mem_rdata), .UNDERRUN(underrun)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          dr;
    logic          pend;
    logic          turn;
    logic          flush;
    logic          unr;
    logic [31:0]   pos;
    logic [31:0]   left;
    logic [AW-1:0] haddr;
    logic [15:0]   hdata;
  } mst_t;

  mst_t m;

  function automatic mst_t step(input mst_t s, input logic f,
                                input logic d, input logic hr,
                                input logic ack, input logic [6:0] lvl,
                                input logic [AW-1:0] ha,
                                input logic [15:0] hd);
    mst_t n;
    logic elig;
    n = s;
    elig = (s.pos < TOTAL) && (int'(lvl) <= FD - BL);
    n.flush = f;
    if (d && lvl == 7'd0) n.unr = 1'b1;
    else if (f) n.unr = 1'b0;
    if (s.rd) begin
      if (f) begin
        n.rd = 1'b0;
        n.dr = 1'b1;
        n.pend = !ack;
      end else if (ack) begin
        n.pos = s.pos + 1;
        n.left = s.left - 1;
        if (n.left == 0 || n.pos == TOTAL) begin
          n.rd = 1'b0;
          n.turn = 1'b1;
        end
      end
    end else if (s.wr) begin
      if (ack) begin
        n.wr = 1'b0;
        n.turn = 1'b0;
      end
    end else if (s.dr) begin
      if (!s.pend || ack) begin
        n.dr = 1'b0;
        n.pend = 1'b0;
      end
    end else if (!f) begin
      if (elig && int'(lvl) <= LW) begin
        n.rd = 1'b1;
        n.left = BL;
      end else if (hr && s.turn) begin
        n.wr = 1'b1;
        n.haddr = ha;
        n.hdata = hd;
      end else if (elig) begin
        n.rd = 1'b1;
        n.left = BL;
      end else if (hr) begin
        n.wr = 1'b1;
        n.haddr = ha;
        n.hdata = hd;
      end
    end
    if (f) n.pos = 0;
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) m <= '0;
    else m <= step(m, fs, de, host_req, mem_ack, level,
                   host_addr, host_wdata);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_mem_req", mem_req, m.rd | m.wr | (m.dr & m.pend));
      if (m.rd | m.wr) begin
        chk("m_mem_we", mem_we, m.wr);
        chk("m_mem_addr", mem_addr,
            m.wr ? m.haddr : m.pos[AW-1:0]);
      end
      if (m.wr) chk("m_mem_wdata", mem_wdata, m.hdata);
      chk("m_fifo_we", fifo_we, m.rd & mem_ack & ~fs);
      if (m.rd & mem_ack & ~fs)
        chk("m_fifo_wdata", fifo_wdata, m.pos[15:0] ^ 16'h5A5A);
      chk("m_host_ready", host_ready, m.wr & mem_ack);
      chk("m_flush", fifo_flush, m.flush);
      chk("m_underrun", underrun, m.unr);
      chk("flush_we_excl", fifo_flush & fifo_we, 0);
    end
  end

  int nok, nhr, nrd, nb, nh, viol, nwe, lasta, found;
  logic prev_req, last_kind, have_last, hr_seen;

  initial begin
    rst = 1; fs = 0; de = 0; host_req = 0; mem_ack = 0;
    level = 7'd60; host_addr = '0; host_wdata = '0;
    repeat (3) cyc();
    cmp_en = 1'b1;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fifo_we", fifo_we, 0);
    chk("rst_flush", fifo_flush, 0);
    chk("rst_underrun", underrun, 0);

    // A: first burst after FRAME_START
    cyc(); rst = 0; mem_ack = 1;
    repeat (2) cyc();
    cyc(); fs = 1; level = 7'd0; #3;
    chk("a_req_c0", mem_req, 0);
    cyc(); fs = 0; #3;
    chk("a_req_c1", mem_req, 0);
    chk("a_flush_c1", fifo_flush, 1);
    nok = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(); #3;
      if (fifo_we && mem_req && int'(mem_addr) == i) nok++;
    end
    chk("a_burst_words", nok, 16);
    cyc(); #3;
    chk("a_gap_req", mem_req, 0);
    cyc(); level = 7'd60; #3;
    chk("a_next_req", mem_req, 1);
    chk("a_next_addr", mem_addr, 16);
    repeat (20) cyc();

    // B: host write while FIFO is full enough
    host_req = 1; host_addr = 19'h100; host_wdata = 16'hABCD;
    nhr = 0; nrd = 0;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (fifo_we) nrd++;
      if (host_ready) begin
        nhr++;
        chk("b_mem_we", mem_we, 1);
        chk("b_mem_addr", mem_addr, 19'h100);
        chk("b_mem_wdata", mem_wdata, 16'hABCD);
      end
      cyc();
      if (nhr != 0) host_req = 0;
    end
    chk("b_host_ready_cnt", nhr, 1);
    chk("b_no_read", nrd, 0);

    // C: alternation, then low-water priority
    level = 7'd30; host_req = 1; host_addr = 19'h200;
    prev_req = 0; have_last = 0; last_kind = 0; hr_seen = 0;
    nb = 0; nh = 0; viol = 0;
    for (int i = 0; i < 120; i++) begin
      #3;
      if (mem_req && !prev_req) begin
        if (have_last && mem_we == last_kind) viol++;
        last_kind = mem_we; have_last = 1;
        if (mem_we) nh++; else nb++;
      end
      prev_req = mem_req;
      hr_seen = host_ready;
      cyc();
      if (hr_seen) begin
        host_addr = host_addr + 19'd1;
        host_wdata = host_wdata + 16'h0101;
      end
    end
    chk("c_alternate", viol, 0);
    chk("c_bursts_ge5", nb >= 5, 1);
    chk("c_hosts_ge5", nh >= 5, 1);
    level = 7'd10;
    repeat (20) cyc();
    nb = 0; nhr = 0; prev_req = 1;
    for (int i = 0; i < 60; i++) begin
      #3;
      if (mem_req && !prev_req) nb++;
      if (host_ready) nhr++;
      prev_req = mem_req;
      cyc();
    end
    chk("c_low_no_host", nhr, 0);
    chk("c_low_bursts_ge3", nb >= 3, 1);
    host_req = 0; level = 7'd60;
    repeat (25) cyc();

    // D: FRAME_START on 5th word with ack stalled
    level = 7'd0; found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      #3;
      if (mem_req && !mem_we) found = 1;
      else cyc();
    end
    chk("d_burst_found", found, 1);
    repeat (3) cyc();
    cyc(); mem_ack = 0; fs = 1; #3;
    chk("d_req_k4", mem_req, 1);
    chk("d_we_k4", fifo_we, 0);
    cyc(); fs = 0; #3;
    chk("d_flush_k5", fifo_flush, 1);
    chk("d_req_k5", mem_req, 1);
    cyc(); #3;
    chk("d_req_k6", mem_req, 1);
    cyc(); mem_ack = 1; #3;
    chk("d_req_k7", mem_req, 1);
    chk("d_discard_k7", fifo_we, 0);
    cyc(); #3;
    chk("d_idle_k8", mem_req, 0);
    cyc(); level = 7'd60; #3;
    chk("d_restart_req", mem_req, 1);
    chk("d_restart_addr", mem_addr, 0);
    repeat (25) cyc();

    // E: full frame
    fs = 1; level = 7'd0;
    cyc(); fs = 0;
    nwe = 0; lasta = -1;
    for (int i = 0; i < TOTAL * 17 / 16 + 40; i++) begin
      #3;
      if (fifo_we) begin
        nwe++;
        lasta = int'(mem_addr);
      end
      cyc();
    end
    chk("e_frame_words", nwe, TOTAL);
    chk("e_last_addr", lasta, TOTAL - 1);
    nwe = 0; nrd = 0;
    for (int i = 0; i < 30; i++) begin
      #3;
      if (fifo_we) nwe++;
      if (mem_req) nrd++;
      cyc();
    end
    chk("e_no_more_we", nwe, 0);
    chk("e_no_more_req", nrd, 0);

    // F: underrun sticky, cleared by FRAME_START, set wins
    de = 1; #3;
    chk("f_unr_before", underrun, 0);
    cyc(); de = 0; #3;
    chk("f_unr_set", underrun, 1);
    repeat (3) cyc();
    #3;
    chk("f_unr_hold", underrun, 1);
    cyc(); fs = 1; #3;
    chk("f_unr_fs_cycle", underrun, 1);
    cyc(); fs = 0; #3;
    chk("f_unr_clr", underrun, 0);
    cyc(); fs = 1; de = 1; #3;
    cyc(); fs = 0; de = 0; #3;
    chk("f_unr_set_wins", underrun, 1);
    level = 7'd60;
    repeat (25) cyc();

    // G: reset in the middle of a burst
    cyc(); fs = 1; level = 7'd0;
    cyc(); fs = 0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      #3;
      if (mem_req && !mem_we) found = 1;
      else cyc();
    end
    chk("g_burst_found", found, 1);
    repeat (2) cyc();
    rst = 1; #3;
    chk("g_req_before", mem_req, 1);
    cyc(); rst = 0; level = 7'd60; #3;
    chk("g_req_dropped", mem_req, 0);
    chk("g_underrun_rst", underrun, 0);
    repeat (5) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
